// File: rtl/kirby_pkg.sv
// Shared types for the Kirby status sequencer. The sprite-select codes are the
// same ones the colour mapper indexes with.
package kirby_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORMAL,
    DAMAGE,
    INHOLE,
    INVINC,
    DEAD
  } state_t;

  localparam logic [1:0] KS_NORMAL = 2'd0;
  localparam logic [1:0] KS_INHOLE = 2'd1;
  localparam logic [1:0] KS_DAMAGE = 2'd2;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [1:0] sprite_code(input state_t s);
    case (s)
      INHOLE:       return KS_INHOLE;
      DAMAGE, DEAD: return KS_DAMAGE;
      default:      return KS_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings VGA vsync into the system clock domain and emits a one-cycle pulse per
// rising edge. Also used by the enemy and star animation blocks.
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic tick
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b000;
    else        sync <= {sync[1:0], frame_clk};
  end

  assign tick = sync[1] & ~sync[2];

endmodule

// File: rtl/kirby_state_ctrl.sv
// Per-frame Kirby status sequencer: damage/hole/invincibility timing, lives and
// game-over, with registered outputs feeding the colour mapper.
//
// state  | meaning
// IDLE   | start screen, lives held at START_LIVES
// NORMAL | playing, hits and holes accepted
// DAMAGE | damage sprite held, life already taken
// INHOLE | in-hole sprite held, life already taken
// INVINC | post-damage/respawn blink, hits ignored
// DEAD   | lives exhausted, held until Gamestart drops
module kirby_state_ctrl
  import kirby_pkg::*;
#(
  parameter int DAMAGE_FRAMES = 60,
  parameter int INVINC_FRAMES = 120,
  parameter int BLINK_FRAMES  = 4,
  parameter int HOLE_FRAMES   = 30,
  parameter int START_LIVES   = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       Gamestart,
  input  logic       hit,
  input  logic       hole_enter,
  output logic [1:0] Kirby_state,
  output logic       Kirby_visible,
  output logic       Invincible,
  output logic       Respawn,
  output logic [1:0] Lives,
  output logic       Game_over
);

  localparam int CNT_W = $clog2(max4(DAMAGE_FRAMES, INVINC_FRAMES, BLINK_FRAMES, HOLE_FRAMES) + 1);
  localparam logic [CNT_W-1:0] DAMAGE_LAST = CNT_W'(DAMAGE_FRAMES - 1);
  localparam logic [CNT_W-1:0] INVINC_LAST = CNT_W'(INVINC_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLE_LAST   = CNT_W'(HOLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_DIV   = CNT_W'(BLINK_FRAMES);
  localparam logic [1:0]       LIVES_INIT  = 2'(START_LIVES);

  logic             tick;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, blink_idx;
  logic [1:0]       lives_nxt;
  logic             respawn_nxt;

  frame_tick_sync u_tick (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  always_comb begin
    state_nxt   = state;
    lives_nxt   = Lives;
    respawn_nxt = 1'b0;
    if (!Gamestart) begin
      state_nxt = IDLE;
      lives_nxt = LIVES_INIT;
    end else begin
      case (state)
        IDLE:   state_nxt = NORMAL;
        NORMAL: begin
          if (tick && hole_enter) state_nxt = INHOLE;
          else if (tick && hit)   state_nxt = DAMAGE;
        end
        DAMAGE: begin
          if (tick && cnt == DAMAGE_LAST) state_nxt = (Lives != 2'd0) ? INVINC : DEAD;
        end
        INHOLE: begin
          if (tick && cnt == HOLE_LAST) begin
            if (Lives != 2'd0) begin
              state_nxt   = INVINC;
              respawn_nxt = 1'b1;
            end else begin
              state_nxt = DEAD;
            end
          end
        end
        INVINC: begin
          if (tick && hole_enter)               state_nxt = INHOLE;
          else if (tick && cnt == INVINC_LAST)  state_nxt = NORMAL;
        end
        DEAD:    state_nxt = DEAD;
        default: state_nxt = IDLE;
      endcase
    end
    // A life is taken on the entry edge so Lives and the sprite move together.
    if ((state_nxt == DAMAGE || state_nxt == INHOLE) && state_nxt != state && lives_nxt != 2'd0)
      lives_nxt = lives_nxt - 2'd1;
    if (state_nxt != state) cnt_nxt = '0;
    else if (tick)          cnt_nxt = cnt + 1'b1;
    else                    cnt_nxt = cnt;
    blink_idx = cnt_nxt / BLINK_DIV;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      Kirby_state   <= KS_NORMAL;
      Kirby_visible <= 1'b1;
      Invincible    <= 1'b0;
      Respawn       <= 1'b0;
      Lives         <= LIVES_INIT;
      Game_over     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      Lives         <= lives_nxt;
      Respawn       <= respawn_nxt;
      Kirby_state   <= sprite_code(state_nxt);
      Invincible    <= (state_nxt == DAMAGE) || (state_nxt == INHOLE) || (state_nxt == INVINC);
      Game_over     <= (state_nxt == DEAD);
      Kirby_visible <= !((state_nxt == INVINC) && blink_idx[0]);
    end
  end

endmodule

// File: tb/tb_kirby_state_ctrl.sv
// Directed bench for the Kirby status sequencer; frames are driven as slow
// vsync pulses deliberately offset from the system clock edges.
module tb_kirby_state_ctrl;
  import kirby_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       Gamestart = 1'b0;
  logic       hit = 1'b0;
  logic       hole_enter = 1'b0;
  logic [1:0] Kirby_state;
  logic       Kirby_visible;
  logic       Invincible;
  logic       Respawn;
  logic [1:0] Lives;
  logic       Game_over;

  int checks = 0;
  int failures = 0;
  int respawn_cnt = 0;
  int tick_cnt = 0;
  int t0;

  kirby_state_ctrl dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_clk     (frame_clk),
    .Gamestart     (Gamestart),
    .hit           (hit),
    .hole_enter    (hole_enter),
    .Kirby_state   (Kirby_state),
    .Kirby_visible (Kirby_visible),
    .Invincible    (Invincible),
    .Respawn       (Respawn),
    .Lives         (Lives),
    .Game_over     (Game_over)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Respawn) respawn_cnt++;
    if (dut.tick) tick_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: vsync high for 4 clocks, low for 4; ends 1 ns after a rising edge.
  task automatic frame();
    @(posedge Clk);
    #3 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #3 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  initial begin
    Gamestart = 1'b1;
    #23 Reset_n = 1'b1;

    // idle frames in NORMAL
    repeat (3) frame();
    check("t1_state", int'(Kirby_state), 0);
    check("t1_lives", int'(Lives), 3);
    check("t1_visible", int'(Kirby_visible), 1);
    check("t1_invinc", int'(Invincible), 0);
    check("t1_respawn", respawn_cnt, 0);

    // hit with exact tick-to-output latency
    hit = 1'b1;
    @(posedge Clk);
    #3 frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 check("t2_pre_tick", int'(Kirby_state), 0);
    @(posedge Clk);
    #1 check("t2_post_tick", int'(Kirby_state), 2);
    check("t2_lives", int'(Lives), 2);
    check("t2_invinc", int'(Invincible), 1);
    hit = 1'b0;
    @(posedge Clk);
    #2 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    repeat (59) frame();
    check("t2_hold59", int'(Kirby_state), 2);
    frame();
    check("t2_hold60", int'(Kirby_state), 0);
    check("t2_invinc_entry", int'(Invincible), 1);
    check("t2_blink0", int'(Kirby_visible), 1);
    // blink pattern, with hits hammered during invincibility
    for (int k = 1; k <= 8; k++) begin
      hit = 1'b1;
      frame();
      check($sformatf("t2_blink%0d", k), int'(Kirby_visible), ((k / 4) % 2 == 0) ? 1 : 0);
    end
    hit = 1'b0;
    check("t4_lives", int'(Lives), 2);
    check("t4_state", int'(Kirby_state), 0);
    repeat (111) frame();
    check("t2_invinc119", int'(Invincible), 1);
    frame();
    check("t2_invinc120", int'(Invincible), 0);
    check("t2_normal", int'(Kirby_state), 0);

    // hit and hole on the same tick: hole wins
    hit = 1'b1;
    hole_enter = 1'b1;
    frame();
    hit = 1'b0;
    hole_enter = 1'b0;
    check("t3_state", int'(Kirby_state), 1);
    check("t3_lives", int'(Lives), 1);
    repeat (29) frame();
    check("t3_hold29", int'(Kirby_state), 1);
    check("t3_no_respawn_yet", respawn_cnt, 0);
    frame();
    check("t3_respawn_once", respawn_cnt, 1);
    check("t3_state_invinc", int'(Kirby_state), 0);
    check("t3_invinc", int'(Invincible), 1);
    repeat (120) frame();
    check("t3_invinc_done", int'(Invincible), 0);

    // last life
    hit = 1'b1;
    frame();
    hit = 1'b0;
    check("t5_lives", int'(Lives), 0);
    check("t5_state", int'(Kirby_state), 2);
    repeat (59) frame();
    check("t5_not_over", int'(Game_over), 0);
    frame();
    check("t5_over", int'(Game_over), 1);
    check("t5_dead_state", int'(Kirby_state), 2);
    check("t5_dead_lives", int'(Lives), 0);
    check("t5_dead_visible", int'(Kirby_visible), 1);
    Gamestart = 1'b0;
    @(posedge Clk);
    #1 check("t5_reload_lives", int'(Lives), 3);
    check("t5_clear_over", int'(Game_over), 0);
    check("t5_idle_state", int'(Kirby_state), 0);
    Gamestart = 1'b1;
    @(posedge Clk);
    #1;

    // asynchronous reset in the middle of DAMAGE
    hit = 1'b1;
    frame();
    hit = 1'b0;
    check("t6_damage", int'(Kirby_state), 2);
    check("t6_lives", int'(Lives), 2);
    repeat (5) frame();
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 check("t6_rst_state", int'(Kirby_state), 0);
    check("t6_rst_lives", int'(Lives), 3);
    check("t6_rst_invinc", int'(Invincible), 0);
    check("t6_rst_visible", int'(Kirby_visible), 1);
    #4 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1 check("t6_no_respawn", respawn_cnt, 1);

    // one tick per vsync rise, edges never aligned to Clk
    t0 = tick_cnt;
    for (int i = 0; i < 3; i++) begin
      #7 frame_clk = 1'b1;
      #37 frame_clk = 1'b0;
      #41;
    end
    repeat (4) @(posedge Clk);
    #1 check("t6_ticks", tick_cnt - t0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
